ddr_rd_stream: RTL and testbench
================================

Name: ddr_rd_stream

Overview:
- DDR read front-end that sits directly upstream of ddr2pbuf and feeds one of its ddr stream ports (ddr1 or ddr2).
- On start, fetches conf_trans_num DDR_W-wide beats from a linear DDR region using AXI-style AR/R channels.
- Buffers returned beats in an internal FIFO and presents them as a valid/ready stream.
- Uses credit-based burst issue, so r_ready is never deasserted and the FIFO can never overflow.

Parameters:
- DDR_W, GLOBAL_PARAM::DDR_W, beat width in bits.
- AXI_AW, 32, DDR byte-address width.
- BURST_LEN, 16, maximum beats per AR burst (power of 2, ≤256).
- FIFO_DEPTH, 64, beat FIFO depth (power of 2, ≥ 2*BURST_LEN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; latches conf_* and begins a transfer.
- done  out  1  high when idle and all beats have been delivered.
- conf_base_addr  in  AXI_AW  byte address of the first beat (DDR_W/8 aligned).
- conf_trans_num  in  12  number of beats to fetch; 0 is legal.
- ar_addr  out  AXI_AW  burst start byte address.
- ar_len  out  8  beats in the burst minus 1.
- ar_valid  out  1  address request valid.
- ar_ready  in  1  address request accepted.
- r_data  in  DDR_W  read data beat.
- r_valid  in  1  read beat valid.
- r_last  in  1  last beat of a burst; used only for checking.
- r_ready  out  1  constant 1 outside reset.
- out_data  out  DDR_W  stream data to ddr2pbuf.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready (1 in the current ddr2pbuf).

Behaviour:
- Reset, asynchronous:
  - FSM to IDLE; done=1; ar_valid=0; out_valid=0; r_ready=0.
  - FIFO emptied; all counters cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On start, latch base address and trans_num; set req_left=trans_num, beat_left=trans_num; done drops to 0 the next cycle.
  - If trans_num==0, go straight to DRAIN.
  - start while not IDLE is ignored.
- ISSUE:
  - Burst size = min(BURST_LEN, req_left).
  - credit = FIFO_DEPTH − fifo_count − outstanding.
  - Raise ar_valid only when credit ≥ burst size.
  - ar_addr/ar_len stay stable while ar_valid=1 && !ar_ready.
  - On an AR handshake:
    - outstanding += burst size (net of any beat retired the same cycle).
    - req_left −= burst size.
    - address += burst size × DDR_W/8.
    - ar_valid deasserts for ≥1 cycle before the next burst; the credit is recomputed.
  - When req_left hits 0, go to DRAIN.
- R channel:
  - r_ready=1 in every state after reset.
  - Each r_valid beat is written to the FIFO and decrements outstanding.
  - A beat arriving with outstanding==0 is a protocol error; it is dropped and sticky err_r is set (internal, visible in sim).
- Output stream:
  - out_valid = FIFO non-empty.
  - Latency from an accepted R beat to out_valid is 1 cycle (registered FIFO write, FWFT read).
  - A pop happens on out_valid && out_ready and decrements beat_left.
- DRAIN → IDLE when beat_left==0 and outstanding==0; done=1 in the same cycle IDLE is entered.
- Simultaneous events:
  - Push and pop in the same cycle leave fifo_count unchanged.
  - AR handshake and R beat in the same cycle update outstanding by (+burst − 1).
- Widths:
  - outstanding and fifo_count are log2(FIFO_DEPTH)+1 bits.
  - The address adder wraps modulo 2^AXI_AW with no error.
- Reset mid-transfer aborts everything; late R beats after a reset are dropped, because outstanding==0.

Optional Feature:
- Macro: DDR_RD_4K_SPLIT_EN.
- Defined: each burst is additionally clipped so it never crosses a 4 KiB address boundary.
  - Burst size = min(BURST_LEN, req_left, (4096 − ar_addr[11:0]) / (DDR_W/8)).
- Undefined: no boundary clipping; the caller guarantees alignment.

Test Plan:
- Basic fetch: DDR_W=512, BURST_LEN=16, base=0x1000, trans_num=40, ar_ready=1, memory model 4-cycle latency, out_ready=1.
  - 3 ARs: (0x1000, len 15), (0x1400, len 15), (0x1800, len 7).
  - 40 beats out in order.
  - done rises 1 cycle after the 40th pop.
- Backpressure: out_ready=0 for 200 cycles, trans_num=200, FIFO_DEPTH=64.
  - Exactly 4 bursts are issued; no further ar_valid until pops occur.
  - r_ready never drops; no FIFO overflow.
  - All 200 beats delivered after out_ready=1.
- Zero length: start with trans_num=0.
  - No ar_valid ever.
  - done goes 1→0→1 within 3 cycles.
- AR stall: ar_ready=0 for 10 cycles on the 2nd burst.
  - ar_addr/ar_len stable throughout.
  - No duplicate or missing burst.
- Async reset mid-transfer: assert rst at beat 20 of 40, release, inject 5 stale R beats.
  - Outputs reset immediately; stale beats dropped; done=1.
  - A new start of 16 beats completes correctly.
- With DDR_RD_4K_SPLIT_EN: base=0x0F80, trans_num=16, DDR_W=512.
  - ARs are (0x0F80, len 1) then (0x1000, len 13).
  - Without the macro: a single AR (0x0F80, len 15).

Source files
------------

// File: rtl/ddr_rd_stream_if.sv
// Bus bundle for ddr_rd_stream: AR/R read channels plus the output beat stream.
// master = the read front-end, slave = DDR memory side and the stream consumer.
interface ddr_rd_stream_if #(
    parameter int unsigned DDR_W  = 512,
    parameter int unsigned AXI_AW = 32
);
    logic [AXI_AW-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic              ar_valid;
    logic              ar_ready;
    logic [DDR_W-1:0]  r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_ready;
    logic [DDR_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              err_r;      // sticky R-channel protocol error, observation only

    modport master (
        output ar_addr, ar_len, ar_valid, r_ready, out_data, out_valid, err_r,
        input  ar_ready, r_data, r_valid, r_last, out_ready
    );

    modport slave (
        input  ar_addr, ar_len, ar_valid, r_ready, out_data, out_valid, err_r,
        output ar_ready, r_data, r_valid, r_last, out_ready
    );
endinterface

// File: rtl/ddr_rd_stream.sv
// DDR read front-end: fetches conf_trans_num beats from a linear region with
// credit-limited AR bursts, buffers them in a FWFT FIFO and streams them out.
// Optional macro DDR_RD_4K_SPLIT_EN clips bursts at 4 KiB address boundaries.
module ddr_rd_stream #(
    parameter int unsigned DDR_W      = 512,
    parameter int unsigned AXI_AW     = 32,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [AXI_AW-1:0] conf_base_addr,
    input  logic [11:0]       conf_trans_num,
    ddr_rd_stream_if.master   bus
);
    localparam int unsigned BEAT_BYTES = DDR_W / 8;
    localparam int unsigned PW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CW         = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            r_state, w_state_next;
    logic [AXI_AW-1:0] r_addr;
    logic [11:0]       r_req_left;
    logic [11:0]       r_beat_left;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wptr, r_rptr;
    logic              r_ar_valid;
    logic              r_rdy;
    logic              r_err;
    logic [DDR_W-1:0]  r_mem [FIFO_DEPTH];

    logic [31:0]       w_burst, w_credit;
`ifdef DDR_RD_4K_SPLIT_EN
    logic [31:0]       w_4k_beats;
`endif
    logic              w_beat, w_push, w_pop, w_ar_hs, w_ar_raise, w_start;

    assign w_beat   = bus.r_valid && r_rdy;
    assign w_push   = w_beat && (r_outstanding != '0);
    assign w_pop    = (r_count != '0) && bus.out_ready;
    assign w_ar_hs  = r_ar_valid && bus.ar_ready;
    assign w_credit = 32'(FIFO_DEPTH) - 32'(r_count) - 32'(r_outstanding);

    // Burst size: remaining requests capped by BURST_LEN (and the 4 KiB page when enabled).
    // Inputs only change on an AR handshake, so ar_len stays stable while ar_valid waits.
    always_comb begin
        w_burst = 32'(r_req_left);
        if (w_burst > BURST_LEN) begin
            w_burst = BURST_LEN;
        end
`ifdef DDR_RD_4K_SPLIT_EN
        w_4k_beats = (32'd4096 - 32'(r_addr[11:0])) / BEAT_BYTES;
        if (w_4k_beats < w_burst) begin
            w_burst = w_4k_beats;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state, transfer start and burst-raise decision.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_ar_raise   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_start      = 1'b1;
                    w_state_next = (conf_trans_num == 12'd0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (w_ar_hs) begin
                    if (r_req_left == 12'(w_burst)) begin
                        w_state_next = DRAIN;
                    end
                end else if (!r_ar_valid && (w_credit >= w_burst)) begin
                    w_ar_raise = 1'b1;
                end
            end
            DRAIN: begin
                if ((r_beat_left == 12'd0) && (r_outstanding == '0)) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Request bookkeeping: address, remaining requests/beats, in-flight beats, errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= '0;
            r_req_left    <= '0;
            r_beat_left   <= '0;
            r_outstanding <= '0;
            r_ar_valid    <= 1'b0;
            r_rdy         <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_start) begin
                r_addr     <= conf_base_addr;
                r_req_left <= conf_trans_num;
            end else if (w_ar_hs) begin
                r_req_left <= r_req_left - 12'(w_burst);
                r_addr     <= r_addr + AXI_AW'(w_burst * BEAT_BYTES);
            end
            if (w_ar_hs) begin
                r_ar_valid <= 1'b0;
            end else if (w_ar_raise) begin
                r_ar_valid <= 1'b1;
            end
            r_outstanding <= r_outstanding + (w_ar_hs ? CW'(w_burst) : '0) - CW'(w_push);
            if (w_start) begin
                r_beat_left <= conf_trans_num;
            end else if (w_pop) begin
                r_beat_left <= r_beat_left - 12'd1;
            end
            // A beat with nothing outstanding is stray; a beat retiring the last
            // outstanding one must close its burst.
            if (w_beat && ((r_outstanding == '0) ||
                           ((r_outstanding == CW'(1)) && !bus.r_last))) begin
                r_err <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; credit issue guarantees no push when full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.r_data;
        end
    end

    assign bus.ar_addr   = r_addr;
    assign bus.ar_len    = 8'(w_burst - 32'd1);
    assign bus.ar_valid  = r_ar_valid;
    assign bus.r_ready   = r_rdy;
    assign bus.out_data  = r_mem[r_rptr];
    assign bus.out_valid = (r_count != '0);
    assign bus.err_r     = r_err;
    assign done          = (r_state == IDLE);
endmodule

// File: tb/tb_ddr_rd_stream.sv
// Directed bench for ddr_rd_stream: DDR memory model with 4-cycle latency,
// AR stall injection, stale-beat injection and output beat checking.
module tb_ddr_rd_stream;
    localparam int unsigned DDR_W  = 512;
    localparam int unsigned AXI_AW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              done;
    logic [AXI_AW-1:0] conf_base_addr = '0;
    logic [11:0]       conf_trans_num = '0;

    ddr_rd_stream_if #(.DDR_W(DDR_W), .AXI_AW(AXI_AW)) bus ();

    ddr_rd_stream #(.DDR_W(DDR_W), .AXI_AW(AXI_AW), .BURST_LEN(16), .FIFO_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .conf_base_addr(conf_base_addr), .conf_trans_num(conf_trans_num), .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int unsigned ar_t_q[$];
    int unsigned cyc;
    int          stall_at = -1;
    int          stale_req = 0;
    int unsigned pop_total = 0, pop_mark = 0, last_pop_cyc = 0, issued = 0, stall_seen = 0;
    logic [31:0] exp_base = '0;
    logic        prev_stall = 1'b0, rst_q = 1'b1;
    logic [31:0] prev_addr = '0;
    logic [7:0]  prev_len = '0;

    function automatic logic [DDR_W-1:0] pat(input logic [31:0] a);
        return {16{a}};
    endfunction

    // Memory model: serves logged ARs in order, 4 cycles after acceptance; also
    // injects stale beats on request and stalls the chosen AR for 10 cycles.
    initial begin
        int rsp_idx, rsp_k, stall_cnt, stale_sent;
        logic [31:0] a;
        rsp_idx = 0; rsp_k = 0; stall_cnt = 0; stale_sent = 0; cyc = 0;
        bus.ar_ready = 1'b1; bus.r_valid = 1'b0; bus.r_last = 1'b0; bus.r_data = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (stall_at == ar_addr_q.size() && bus.ar_valid && stall_cnt < 10) begin
                bus.ar_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus.ar_ready = 1'b1;
            end
            if (rst) begin
                rsp_idx = ar_addr_q.size(); rsp_k = 0;
                bus.r_valid = 1'b0; bus.r_last = 1'b0;
            end else if (stale_sent < stale_req) begin
                bus.r_valid = 1'b1; bus.r_last = 1'b0;
                bus.r_data = pat(32'hDEAD0000 + 32'(stale_sent));
                stale_sent++;
            end else if (rsp_idx < ar_addr_q.size() && cyc >= ar_t_q[rsp_idx] + 4) begin
                a = ar_addr_q[rsp_idx] + 32'(rsp_k * 64);
                bus.r_valid = 1'b1;
                bus.r_data  = pat(a);
                bus.r_last  = (rsp_k == int'(ar_len_q[rsp_idx]));
                if (rsp_k == int'(ar_len_q[rsp_idx])) begin
                    rsp_idx++; rsp_k = 0;
                end else begin
                    rsp_k++;
                end
            end else begin
                bus.r_valid = 1'b0; bus.r_last = 1'b0;
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input logic [DDR_W-1:0] obs, input logic [DDR_W-1:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    // One cycle of observation at the falling edge.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            issued = pop_total;
        end else if (!rst_q) begin
            chk(32'(bus.r_ready), 32'd1, "r_ready_high");
        end
        rst_q = rst;
        if (prev_stall) begin
            chk(32'(bus.ar_valid), 32'd1, "ar_hold_valid");
            chk(bus.ar_addr, prev_addr, "ar_hold_addr");
            chk(32'(bus.ar_len), 32'(prev_len), "ar_hold_len");
        end
        prev_stall = bus.ar_valid && !bus.ar_ready && !rst;
        if (prev_stall) begin
            stall_seen++;
            prev_addr = bus.ar_addr;
            prev_len  = bus.ar_len;
        end
        if (bus.ar_valid && bus.ar_ready && !rst) begin
            ar_addr_q.push_back(bus.ar_addr);
            ar_len_q.push_back(bus.ar_len);
            ar_t_q.push_back(cyc);
            issued += int'(bus.ar_len) + 1;
            chk(32'(issued - pop_total <= 64), 32'd1, "fifo_bound");
        end
        if (bus.out_valid && bus.out_ready && !rst) begin
            chkw(bus.out_data, pat(exp_base + 32'((pop_total - pop_mark) * 64)), "out_data");
            pop_total++;
            last_pop_cyc = cyc + 1;
        end
    endtask

    task automatic run_start(input logic [31:0] base, input logic [11:0] n);
        sync();
        conf_base_addr = base; conf_trans_num = n; start = 1'b1;
        exp_base = base; pop_mark = pop_total;
        tick();
        sync();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(32'(seen), 32'd1, tag);
    endtask

    initial begin
        int unsigned ar0, ar_mid, pops_mid, s0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        chk(32'(done), 32'd1, "rst_done");
        chk(32'(bus.ar_valid), 32'd0, "rst_ar_valid");
        chk(32'(bus.out_valid), 32'd0, "rst_out_valid");
        chk(32'(bus.r_ready), 32'd0, "rst_r_ready");
        sync();
        rst = 1'b0;
        repeat (2) tick();
        chk(32'(bus.err_r), 32'd0, "rst_err_r");

        // Basic fetch: 40 beats from 0x1000
        ar0 = ar_addr_q.size();
        run_start(32'h1000, 12'd40);
        tick();
        chk(32'(done), 32'd0, "t1_done_drop");
        wait_done(400, "t1_done_timeout");
        chk(cyc, last_pop_cyc + 1, "t1_done_latency");
        chk(32'(ar_addr_q.size() - ar0), 32'd3, "t1_ar_count");
        chk(ar_addr_q[ar0],     32'h1000, "t1_ar0_addr"); chk(32'(ar_len_q[ar0]),     32'd15, "t1_ar0_len");
        chk(ar_addr_q[ar0 + 1], 32'h1400, "t1_ar1_addr"); chk(32'(ar_len_q[ar0 + 1]), 32'd15, "t1_ar1_len");
        chk(ar_addr_q[ar0 + 2], 32'h1800, "t1_ar2_addr"); chk(32'(ar_len_q[ar0 + 2]), 32'd7,  "t1_ar2_len");
        chk(pop_total - pop_mark, 32'd40, "t1_pops");
        chk(32'(bus.err_r), 32'd0, "t1_err_r");

        // Backpressure: 200 beats with the consumer stalled
        sync();
        bus.out_ready = 1'b0;
        ar0 = ar_addr_q.size();
        run_start(32'h0, 12'd200);
        repeat (200) tick();
        chk(32'(ar_addr_q.size() - ar0), 32'd4, "t2_ar_credit_limit");
        chk(32'(bus.ar_valid), 32'd0, "t2_ar_valid_held_off");
        chk(32'(bus.out_valid), 32'd1, "t2_out_valid");
        chk(pop_total - pop_mark, 32'd0, "t2_no_pops");
        sync();
        bus.out_ready = 1'b1;
        wait_done(2000, "t2_done_timeout");
        chk(pop_total - pop_mark, 32'd200, "t2_pops");
        chk(32'(ar_addr_q.size() - ar0), 32'd13, "t2_ar_count");
        chk(ar_addr_q[ar0 + 12], 32'h3000, "t2_last_ar_addr");
        chk(32'(ar_len_q[ar0 + 12]), 32'd7, "t2_last_ar_len");

        // Zero length
        ar0 = ar_addr_q.size();
        run_start(32'h7000, 12'd0);
        tick();
        chk(32'(done), 32'd0, "t3_done_low");
        tick();
        chk(32'(done), 32'd1, "t3_done_high");
        repeat (5) tick();
        chk(32'(ar_addr_q.size() - ar0), 32'd0, "t3_no_ar");

        // AR stall on the second burst
        ar0 = ar_addr_q.size();
        s0 = stall_seen;
        stall_at = int'(ar0) + 1;
        run_start(32'h2000, 12'd40);
        wait_done(600, "t4_done_timeout");
        chk(stall_seen - s0, 32'd10, "t4_stall_cycles");
        chk(32'(ar_addr_q.size() - ar0), 32'd3, "t4_ar_count");
        chk(ar_addr_q[ar0],     32'h2000, "t4_ar0_addr"); chk(32'(ar_len_q[ar0]),     32'd15, "t4_ar0_len");
        chk(ar_addr_q[ar0 + 1], 32'h2400, "t4_ar1_addr"); chk(32'(ar_len_q[ar0 + 1]), 32'd15, "t4_ar1_len");
        chk(ar_addr_q[ar0 + 2], 32'h2800, "t4_ar2_addr"); chk(32'(ar_len_q[ar0 + 2]), 32'd7,  "t4_ar2_len");
        chk(pop_total - pop_mark, 32'd40, "t4_pops");

        // Asynchronous reset at beat 20 of 40, then stale beats
        run_start(32'h4000, 12'd40);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (pop_total - pop_mark >= 20) break;
        end
        chk(32'(pop_total - pop_mark >= 20), 32'd1, "t5_reach_beat20");
        sync();
        #1 rst = 1'b1;
        #1;
        chk(32'(done), 32'd1, "t5_async_done");
        chk(32'(bus.ar_valid), 32'd0, "t5_async_ar_valid");
        chk(32'(bus.out_valid), 32'd0, "t5_async_out_valid");
        chk(32'(bus.r_ready), 32'd0, "t5_async_r_ready");
        repeat (3) tick();
        sync();
        rst = 1'b0;
        ar_mid = ar_addr_q.size();
        pops_mid = pop_total;
        sync();
        stale_req = 5;
        repeat (10) tick();
        chk(32'(bus.out_valid), 32'd0, "t5_stale_dropped");
        chk(32'(done), 32'd1, "t5_done_after_stale");
        chk(32'(bus.err_r), 32'd1, "t5_err_r_set");
        chk(32'(ar_addr_q.size() - ar_mid), 32'd0, "t5_no_ar_after_reset");
        chk(pop_total - pops_mid, 32'd0, "t5_no_pops_after_reset");
        ar0 = ar_addr_q.size();
        run_start(32'h5000, 12'd16);
        wait_done(300, "t5_restart_timeout");
        chk(32'(ar_addr_q.size() - ar0), 32'd1, "t5_restart_ar_count");
        chk(ar_addr_q[ar0], 32'h5000, "t5_restart_ar_addr");
        chk(32'(ar_len_q[ar0]), 32'd15, "t5_restart_ar_len");
        chk(pop_total - pop_mark, 32'd16, "t5_restart_pops");

        // Burst straddling a 4 KiB boundary
        ar0 = ar_addr_q.size();
        run_start(32'h0F80, 12'd16);
        wait_done(300, "t6_done_timeout");
`ifdef DDR_RD_4K_SPLIT_EN
        chk(32'(ar_addr_q.size() - ar0), 32'd2, "t6_ar_count");
        chk(ar_addr_q[ar0],     32'h0F80, "t6_ar0_addr"); chk(32'(ar_len_q[ar0]),     32'd1,  "t6_ar0_len");
        chk(ar_addr_q[ar0 + 1], 32'h1000, "t6_ar1_addr"); chk(32'(ar_len_q[ar0 + 1]), 32'd13, "t6_ar1_len");
`else
        chk(32'(ar_addr_q.size() - ar0), 32'd1, "t6_ar_count");
        chk(ar_addr_q[ar0], 32'h0F80, "t6_ar0_addr");
        chk(32'(ar_len_q[ar0]), 32'd15, "t6_ar0_len");
`endif
        chk(pop_total - pop_mark, 32'd16, "t6_pops");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
